instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_reg.sv | 31 +++
 rtl/instr_fetch.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the fetch FSM state encoding and the datapath widths used by
// the fetch unit.
package cpu_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int WORD_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;

  localparam logic [3:0] FETCH_TIMEOUT_MAX = 4'd15;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: a 32-bit register with parallel load and increment.
// When load and inc are both set, load wins. Increment wraps modulo 2^32.
module pc_reg
  import cpu_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_value,
  input  logic              inc,
  output logic [WORD_W-1:0] pc
);

  logic [WORD_W-1:0] pc_r;

  // PC state: asynchronous clear, then load takes priority over increment
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_r <= 32'd0;
    end else if (load) begin
      pc_r <= load_value;
    end else if (inc) begin
      pc_r <= pc_r + 32'd1;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: an IDLE/ADDR/WAIT/DONE FSM that reads one word from RAM into IR.
// Define FETCH_TIMEOUT_EN to abort a stalled read after FETCH_TIMEOUT_MAX wait cycles.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  fetch_req,
  input  logic                  Stop,
  input  logic                  pc_load,
  input  logic [WORD_W-1:0]     pc_load_value,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_read,
  output logic [WORD_W-1:0]     IR,
  output logic                  ir_valid,
  output logic [WORD_W-1:0]     PC,
  output logic                  fetch_busy,
  output logic                  fetch_err
);

  fetch_state_t          state_r;
  fetch_state_t          next_state_s;
  logic                  pc_ld_s;
  logic                  pc_inc_s;
  logic                  addr_ld_s;
  logic                  ir_ld_s;
  logic                  timeout_s;
  logic [WORD_W-1:0]     pc_s;
  logic [MEM_ADDR_W-1:0] mem_addr_r;
  logic [WORD_W-1:0]     ir_r;
  logic                  mem_read_r;
  logic                  ir_valid_r;
  logic                  fetch_busy_r;

  pc_reg u_pc_reg (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (pc_ld_s),
    .load_value (pc_load_value),
    .inc        (pc_inc_s),
    .pc         (pc_s)
  );

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= FETCH_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; pc_load in IDLE blocks a fetch start in the same cycle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH_IDLE: begin
        if (!pc_load && fetch_req && !Stop) begin
          next_state_s = FETCH_ADDR;
        end else begin
          next_state_s = FETCH_IDLE;
        end
      end
      FETCH_ADDR: next_state_s = FETCH_WAIT;
      FETCH_WAIT: begin
        if (mem_ready) begin
          next_state_s = FETCH_DONE;
        end else if (timeout_s) begin
          next_state_s = FETCH_IDLE;
        end else begin
          next_state_s = FETCH_WAIT;
        end
      end
      FETCH_DONE: next_state_s = FETCH_IDLE;
      default:    next_state_s = FETCH_IDLE;
    endcase
  end

  // FSM output logic: datapath strobes for PC, address latch and IR
  always_comb begin
    pc_ld_s   = 1'b0;
    pc_inc_s  = 1'b0;
    addr_ld_s = 1'b0;
    ir_ld_s   = 1'b0;
    case (state_r)
      FETCH_IDLE: begin
        if (pc_load) begin
          pc_ld_s = 1'b1;
        end else if (fetch_req && !Stop) begin
          addr_ld_s = 1'b1;
        end else begin
          pc_ld_s   = 1'b0;
          addr_ld_s = 1'b0;
        end
      end
      FETCH_WAIT: begin
        if (mem_ready) begin
          ir_ld_s  = 1'b1;
          pc_inc_s = 1'b1;
        end else begin
          ir_ld_s  = 1'b0;
          pc_inc_s = 1'b0;
        end
      end
      default: begin
        pc_ld_s   = 1'b0;
        pc_inc_s  = 1'b0;
        addr_ld_s = 1'b0;
        ir_ld_s   = 1'b0;
      end
    endcase
  end

  // Registered outputs; ir_valid follows DONE by one edge, so it never overlaps a RAM read
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem_addr_r   <= 9'd0;
      ir_r         <= 32'd0;
      mem_read_r   <= 1'b0;
      ir_valid_r   <= 1'b0;
      fetch_busy_r <= 1'b0;
    end else begin
      mem_read_r   <= (next_state_s == FETCH_ADDR) || (next_state_s == FETCH_WAIT);
      ir_valid_r   <= (state_r == FETCH_DONE);
      fetch_busy_r <= (next_state_s != FETCH_IDLE);
      if (addr_ld_s) begin
        mem_addr_r <= pc_s[MEM_ADDR_W-1:0];
      end else begin
        mem_addr_r <= mem_addr_r;
      end
      if (ir_ld_s) begin
        ir_r <= mem_rdata;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt_r;
  logic       fetch_err_r;

  // Abort on the stalled wait cycle that brings the count up to FETCH_TIMEOUT_MAX
  assign timeout_s = (state_r == FETCH_WAIT) && !mem_ready &&
                     (tmo_cnt_r == (FETCH_TIMEOUT_MAX - 4'd1));

  // Wait-cycle counter (cleared on the way into WAIT) and sticky error flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tmo_cnt_r   <= 4'd0;
      fetch_err_r <= 1'b0;
    end else begin
      if (state_r == FETCH_ADDR) begin
        tmo_cnt_r <= 4'd0;
      end else if ((state_r == FETCH_WAIT) && !mem_ready) begin
        tmo_cnt_r <= tmo_cnt_r + 4'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      if (timeout_s) begin
        fetch_err_r <= 1'b1;
      end else begin
        fetch_err_r <= fetch_err_r;
      end
    end
  end

  assign fetch_err = fetch_err_r;
`else
  assign timeout_s = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign mem_addr   = mem_addr_r;
  assign mem_read   = mem_read_r;
  assign IR         = ir_r;
  assign ir_valid   = ir_valid_r;
  assign PC         = pc_s;
  assign fetch_busy = fetch_busy_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with hand-computed expected values.
module tb_instr_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        Stop = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_value = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [8:0]  mem_addr;
  logic        mem_read;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] PC;
  logic        fetch_busy;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  instr_fetch dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .fetch_req     (fetch_req),
    .Stop          (Stop),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .IR            (IR),
    .ir_valid      (ir_valid),
    .PC            (PC),
    .fetch_busy    (fetch_busy),
    .fetch_err     (fetch_err)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One fetch: request sampled at edge 0, mem_ready held for one cycle after
  // 'delay' extra WAIT cycles; returns edges from the sampling edge to ir_valid.
  task automatic run_fetch(input logic [31:0] data, input int delay, output int latency);
    fetch_req = 1'b1;
    mem_rdata = data;
    tick();
    fetch_req = 1'b0;
    latency = 0;
    tick();
    latency = 1;
    for (int i = 0; i < delay; i++) begin
      tick();
      latency++;
    end
    mem_ready = 1'b1;
    tick();
    latency++;
    mem_ready = 1'b0;
    while (!ir_valid && latency < 20) begin
      tick();
      latency++;
    end
    check_eq("ir_valid_seen", 32'(ir_valid), 32'd1);
  endtask

  initial begin
    // Reset state, before any clock edge
    #2;
    check_eq("rst_pc",       PC, 32'd0);
    check_eq("rst_ir",       IR, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_ir_valid", 32'(ir_valid), 32'd0);
    check_eq("rst_busy",     32'(fetch_busy), 32'd0);
    check_eq("rst_err",      32'(fetch_err), 32'd0);
    tick();
    tick();
    @(negedge Clock);
    Reset = 1'b0;
    tick();

    // Basic fetch with minimum latency
    run_fetch(32'h1800_0000, 0, lat);
    check_eq("basic_latency", 32'(lat), 32'd3);
    check_eq("basic_ir", IR, 32'h1800_0000);
    check_eq("basic_opcode", 32'(IR[31:27]), 32'd3);
    check_eq("basic_pc", PC, 32'd1);
    check_eq("basic_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("basic_busy", 32'(fetch_busy), 32'd0);
    tick();
    check_eq("basic_pulse_one_cycle", 32'(ir_valid), 32'd0);

    // mem_ready in IDLE is ignored, IR holds
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ready = 1'b0;
    check_eq("idle_ready_ir", IR, 32'h1800_0000);
    check_eq("idle_ready_busy", 32'(fetch_busy), 32'd0);

    // PC load to 0x1FF then two fetches, address wraps to 0
    pc_load = 1'b1;
    pc_load_value = 32'h0000_01FF;
    tick();
    pc_load = 1'b0;
    check_eq("load_pc", PC, 32'h0000_01FF);
    run_fetch(32'hA5A5_0001, 2, lat);
    check_eq("wrap1_latency", 32'(lat), 32'd5);
    check_eq("wrap1_mem_addr", 32'(mem_addr), 32'h1FF);
    check_eq("wrap1_pc", PC, 32'h0000_0200);
    check_eq("wrap1_ir", IR, 32'hA5A5_0001);
    run_fetch(32'h1234_5678, 0, lat);
    check_eq("wrap2_mem_addr", 32'(mem_addr), 32'h000);
    check_eq("wrap2_pc", PC, 32'h0000_0201);

    // pc_load and fetch_req together: load wins, then fetch from new PC
    pc_load = 1'b1;
    pc_load_value = 32'h0000_0040;
    fetch_req = 1'b1;
    tick();
    pc_load = 1'b0;
    check_eq("prio_pc", PC, 32'h0000_0040);
    check_eq("prio_busy", 32'(fetch_busy), 32'd0);
    mem_rdata = 32'h0BAD_F00D;
    tick();
    check_eq("prio_fetch_busy", 32'(fetch_busy), 32'd1);
    check_eq("prio_mem_read", 32'(mem_read), 32'd1);
    check_eq("prio_mem_addr", 32'(mem_addr), 32'h040);
    // pc_load and fetch_req during ADDR are ignored
    pc_load = 1'b1;
    pc_load_value = 32'h0000_DEAD;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b0;
    check_eq("busy_load_ignored", PC, 32'h0000_0040);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("prio_done_pc", PC, 32'h0000_0041);
    check_eq("prio_done_ir", IR, 32'h0BAD_F00D);
    check_eq("prio_done_mem_read", 32'(mem_read), 32'd0);
    tick();
    check_eq("prio_ir_valid", 32'(ir_valid), 32'd1);
    tick();
    check_eq("no_queue_busy", 32'(fetch_busy), 32'd0);

    // Stop in WAIT lets the fetch finish, then blocks new fetches
    fetch_req = 1'b1;
    mem_rdata = 32'hCAFE_BABE;
    tick();
    fetch_req = 1'b0;
    tick();
    Stop = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("stop_wait_mem_read", 32'(mem_read), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("stop_ir", IR, 32'hCAFE_BABE);
    check_eq("stop_pc", PC, 32'h0000_0042);
    tick();
    check_eq("stop_ir_valid", 32'(ir_valid), 32'd1);
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("stop_blocks_busy", 32'(fetch_busy), 32'd0);
    check_eq("stop_blocks_read", 32'(mem_read), 32'd0);
    fetch_req = 1'b0;
    Stop = 1'b0;

    // PC wrap from 0xFFFFFFFF to 0
    pc_load = 1'b1;
    pc_load_value = 32'hFFFF_FFFF;
    tick();
    pc_load = 1'b0;
    run_fetch(32'h0000_0007, 1, lat);
    check_eq("pcwrap_pc", PC, 32'd0);
    check_eq("pcwrap_mem_addr", 32'(mem_addr), 32'h1FF);

    // Asynchronous reset in the middle of WAIT
    pc_load = 1'b1;
    pc_load_value = 32'h0000_0010;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    fetch_req = 1'b0;
    tick();
    check_eq("midrst_pre_read", 32'(mem_read), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("midrst_mem_read", 32'(mem_read), 32'd0);
    check_eq("midrst_pc", PC, 32'd0);
    check_eq("midrst_busy", 32'(fetch_busy), 32'd0);
    check_eq("midrst_ir", IR, 32'd0);
    check_eq("midrst_ir_valid", 32'(ir_valid), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("late_ready_ir_valid", 32'(ir_valid), 32'd0);
    check_eq("late_ready_ir", IR, 32'd0);
    check_eq("late_ready_busy", 32'(fetch_busy), 32'd0);

    // Memory that never answers
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    check_eq("tmo_not_yet_err", 32'(fetch_err), 32'd0);
    check_eq("tmo_not_yet_read", 32'(mem_read), 32'd1);
    tick();
    check_eq("tmo_err", 32'(fetch_err), 32'd1);
    check_eq("tmo_busy", 32'(fetch_busy), 32'd0);
    check_eq("tmo_mem_read", 32'(mem_read), 32'd0);
    check_eq("tmo_pc", PC, 32'd0);
    tick();
    check_eq("tmo_no_ir_valid", 32'(ir_valid), 32'd0);
    check_eq("tmo_err_sticky", 32'(fetch_err), 32'd1);
`else
    for (int i = 0; i < 100; i++) tick();
    check_eq("stall_mem_read", 32'(mem_read), 32'd1);
    check_eq("stall_busy", 32'(fetch_busy), 32'd1);
    check_eq("stall_err", 32'(fetch_err), 32'd0);
    check_eq("stall_pc", PC, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
